mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single core-side memory port between the IFU (read-only fetch) and the
// LSU (load/store issued from EXU results o_mem_ren/o_mem_wen/o_mem_wmask).
// Round-robin arbitration, one outstanding transaction, latched request fields,
// response routing to the owner, watchdog timeout returning an error response.
// PARAMETERS
// ADDR_W         32   address width
// DATA_W         32   data width; wmask is DATA_W/8 bits
// TIMEOUT_CYCLES 255  cycles in REQ+RESP before forced error response; 0 disables
// PORTS
// i_clock        in   1        clock, all logic on posedge
// i_reset_n      in   1        synchronous reset, active-low
// i_ifu_req      in   1        IFU read request, held until its o_ifu_rvalid
// i_ifu_addr     in   ADDR_W   IFU fetch address
// o_ifu_rvalid   out  1        one-cycle response pulse to IFU
// o_ifu_rdata    out  DATA_W   fetch data, valid with o_ifu_rvalid
// o_ifu_err      out  1        response is error (bus error or timeout)
// i_lsu_req      in   1        LSU request, held until its o_lsu_rvalid
// i_lsu_wen      in   1        1 = store, 0 = load
// i_lsu_addr     in   ADDR_W   LSU address
// i_lsu_wdata    in   DATA_W   store data
// i_lsu_wmask    in   DATA_W/8 store byte mask
// o_lsu_rvalid   out  1        one-cycle completion pulse (loads and stores)
// o_lsu_rdata    out  DATA_W   load data (0 for stores)
// o_lsu_err      out  1        response is error
// o_mem_valid    out  1        request valid to memory
// i_mem_ready    in   1        memory accepts request when valid&&ready
// o_mem_addr     out  ADDR_W   latched address
// o_mem_wen      out  1        latched write enable (0 for IFU)
// o_mem_wdata    out  DATA_W   latched store data (0 for IFU)
// o_mem_wmask    out  DATA_W/8 latched mask (0 for IFU and loads)
// i_mem_rvalid   in   1        memory response valid
// i_mem_rdata    in   DATA_W   memory read data
// i_mem_err      in   1        memory response error
// o_busy         out  1        state != IDLE
// o_owner        out  1        current/last grant: 0 = IFU, 1 = LSU
// BEHAVIOUR
// - Reset (i_reset_n==0 at posedge): state=IDLE, o_mem_valid=0, latched fields=0, timer=0,
//   last_owner=LSU (IFU wins first tie), o_busy=0, o_owner=1; all response outputs 0.
//   Reset mid-transaction abandons it: no response pulse; late i_mem_rvalid ignored.
// - FSM IDLE -> REQ -> RESP -> IDLE.
// - IDLE: sample requests. One requester -> grant it. Both -> grant the one != last_owner.
//   On grant edge latch addr/wen/wdata/wmask, set owner, go REQ. None -> stay IDLE.
// - REQ: o_mem_valid=1 with latched fields, stable until i_mem_ready; on valid&&ready edge go RESP.
// - RESP: wait i_mem_rvalid. In that cycle owner's o_*_rvalid=1 (combinational), rdata=i_mem_rdata
//   (0 for stores), err=i_mem_err; other requester's outputs 0. Next edge: IDLE, last_owner=owner.
// - i_mem_rvalid in the same cycle as the accepting handshake is not a response; it is ignored.
// - Requester drops i_*_req in the cycle after its pulse unless issuing a new request; new
//   request then competes in IDLE. Min latency: req cycle 0, o_mem_valid cycle 1, ready cycle 1,
//   rvalid cycle 2 -> pulse cycle 2; next grant earliest cycle 3 (one IDLE cycle between).
// - Timer: clears on grant, increments each REQ/RESP cycle. If TIMEOUT_CYCLES!=0 and timer
//   reaches TIMEOUT_CYCLES with no completion: owner pulse with err=1, rdata=0, o_mem_valid drops,
//   go IDLE, last_owner=owner. Real completion in the same cycle wins over timeout.
// - Request changes while granted are ignored (fields latched). Owner dropping req early does not
//   abort; response still pulses.
// TESTING
// - IFU only, addr 0x80000000, ready at once, rvalid+rdata 0x00000413 next -> o_ifu_rvalid
//   1 cycle with 0x00000413, err=0; o_mem_wen=0, wmask=0.
// - Both req after reset -> IFU first, then LSU; keep both asserting -> grants alternate IFU,LSU,IFU,LSU.
// - LSU store addr 0x80001000 wdata 0xDEADBEEF wmask 4'b0011, ready stalled 5 cycles -> fields stable
//   throughout; o_lsu_rvalid with rdata 0 on rvalid.
// - TIMEOUT_CYCLES=4, memory never ready -> after 4 busy cycles o_ifu_rvalid=1, err=1, rdata=0; IDLE.
// - LSU load, i_mem_err=1 on response -> o_lsu_err=1, o_ifu_* stay 0.
// - i_reset_n low during RESP, then stray i_mem_rvalid -> no response pulse, o_busy=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters plus the memory (whatever sits around the arbiter).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // IFU fetch port
  logic              i_ifu_req;
  logic [ADDR_W-1:0] i_ifu_addr;
  logic              o_ifu_rvalid;
  logic [DATA_W-1:0] o_ifu_rdata;
  logic              o_ifu_err;

  // LSU load/store port
  logic              i_lsu_req;
  logic              i_lsu_wen;
  logic [ADDR_W-1:0] i_lsu_addr;
  logic [DATA_W-1:0] i_lsu_wdata;
  logic [MASK_W-1:0] i_lsu_wmask;
  logic              o_lsu_rvalid;
  logic [DATA_W-1:0] o_lsu_rdata;
  logic              o_lsu_err;

  // Memory port
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wen;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [MASK_W-1:0] o_mem_wmask;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_err;

  modport slave (
    input  i_ifu_req, i_ifu_addr,
    output o_ifu_rvalid, o_ifu_rdata, o_ifu_err,
    input  i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
    output o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err
  );

  modport master (
    output i_ifu_req, i_ifu_addr,
    input  o_ifu_rvalid, o_ifu_rdata, o_ifu_err,
    output i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
    input  o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IFU (fetch reads) and the LSU (loads and
// stores). Round-robin arbitration, a single outstanding transaction with the
// request fields latched at grant, response routed back to the owner, and a
// watchdog that turns a stuck transaction into an error response.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic                o_busy,
  output logic                o_owner
);

  localparam int MASK_W  = DATA_W / 8;
  localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  logic [1:0]         state;
  logic               owner;      // current grant while busy, last grant while idle
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_wen;
  logic [DATA_W-1:0]  lat_wdata;
  logic [MASK_W-1:0]  lat_wmask;
  logic [TIMER_W-1:0] timer;

  logic               grant_ifu;
  logic               grant_lsu;
  logic               mem_done;
  logic               timeout;
  logic               resp_fire;
  logic [DATA_W-1:0]  resp_data;
  logic               resp_err;

  // Round-robin grant decision, only evaluated while the port is free.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves it unassigned and infers a latch.
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == ST_IDLE) begin
      if (bus.i_ifu_req && bus.i_lsu_req) begin
        // Tie goes to whoever did not own the port last.
        grant_ifu = (owner == OWNER_LSU);
        grant_lsu = (owner == OWNER_IFU);
      end else begin
        grant_ifu = bus.i_ifu_req;
        grant_lsu = bus.i_lsu_req;
      end
    end
  end

  // A real memory response only counts once the request has been accepted;
  // i_mem_rvalid during REQ (including the accepting cycle) is ignored.
  assign mem_done  = (state == ST_RESP) && bus.i_mem_rvalid;
  // A real completion in the watchdog cycle takes precedence over the timeout.
  assign timeout   = TIMEOUT_EN && (state != ST_IDLE) && (timer == TIMER_LIMIT) && !mem_done;
  assign resp_fire = mem_done || timeout;
  // Stores and timeouts return zero data.
  assign resp_data = (mem_done && !lat_wen) ? bus.i_mem_rdata : '0;
  assign resp_err  = timeout || (mem_done && bus.i_mem_err);

  // Memory request side: held stable from the latched fields until accepted.
  assign bus.o_mem_valid = (state == ST_REQ) && !timeout;
  assign bus.o_mem_addr  = lat_addr;
  assign bus.o_mem_wen   = lat_wen;
  assign bus.o_mem_wdata = lat_wdata;
  assign bus.o_mem_wmask = lat_wmask;

  // Response routing: only the owner sees the pulse, the other side stays 0.
  assign bus.o_ifu_rvalid = resp_fire && (owner == OWNER_IFU);
  assign bus.o_ifu_rdata  = (owner == OWNER_IFU) ? resp_data : '0;
  assign bus.o_ifu_err    = resp_err && (owner == OWNER_IFU);
  assign bus.o_lsu_rvalid = resp_fire && (owner == OWNER_LSU);
  assign bus.o_lsu_rdata  = (owner == OWNER_LSU) ? resp_data : '0;
  assign bus.o_lsu_err    = resp_err && (owner == OWNER_LSU);

  assign o_busy  = (state != ST_IDLE);
  assign o_owner = owner;

  // Transaction FSM, field latches and watchdog timer.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      owner     <= OWNER_LSU;   // IFU wins the first tie after reset
      lat_addr  <= '0;
      lat_wen   <= 1'b0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      timer     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_lsu) begin
            state     <= ST_REQ;
            owner     <= OWNER_LSU;
            timer     <= '0;
            lat_addr  <= bus.i_lsu_addr;
            lat_wen   <= bus.i_lsu_wen;
            // Loads carry no store data or byte mask onto the bus.
            lat_wdata <= bus.i_lsu_wen ? bus.i_lsu_wdata : '0;
            lat_wmask <= bus.i_lsu_wen ? bus.i_lsu_wmask : '0;
          end else if (grant_ifu) begin
            state     <= ST_REQ;
            owner     <= OWNER_IFU;
            timer     <= '0;
            lat_addr  <= bus.i_ifu_addr;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= '0;
          end
        end
        ST_REQ: begin
          if (timeout) begin
            state <= ST_IDLE;
          end else if (bus.i_mem_ready) begin
            state <= ST_RESP;
          end
          if (TIMEOUT_EN) begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_fire) begin
            state <= ST_IDLE;
          end
          if (TIMEOUT_EN) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
